spi_master_ctrl: RTL and testbench

Single-clock SPI master that turns parallel 10-bit command words into framed serial transactions for the SPI slave / single-port RAM block. It drives `ss_n` and `mosi`, and for read-data commands captures the 8-bit reply on `miso`. It is the upstream stage of the slave and lets a host or test sequencer issue RAM accesses without bit-banging.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: command opcodes, frame widths and master FSM encoding.
// The slave decodes the same opcodes, so both ends import this package.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_GAP
    } state_e;

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI master: frames a 10-bit command as select bit + 10 data bits on mosi and,
// for RD_DATA commands, waits RD_WAIT cycles then shifts in an 8-bit reply from miso.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd_word,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [3:0] WAIT_LD = 4'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
    localparam logic [3:0] GAP_LD  = 4'(GAP - 1);
    localparam logic [3:0] SEND_LD = 4'(CMD_W - 1);
    localparam logic [3:0] RECV_LD = 4'(DATA_W - 1);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [CMD_W-1:0]    tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_frame_q;
    logic                ss_n_q;
    logic                mosi_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_frame_q <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_SEL;
                        tx_q       <= cmd_word;
                        rd_frame_q <= (cmd_word[CMD_W-1 -: 2] == RD_DATA);
                        ss_n_q     <= 1'b0;
                        mosi_q     <= cmd_word[CMD_W-1];
                        busy_q     <= 1'b1;
                    end
                end
                // The select bit is the opcode MSB; the full word follows it.
                S_SEL: begin
                    state_q <= S_SEND;
                    cnt_q   <= SEND_LD;
                    mosi_q  <= tx_q[CMD_W-1];
                    tx_q    <= {tx_q[CMD_W-2:0], 1'b0};
                end
                S_SEND: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q  <= cnt_q - 4'd1;
                        mosi_q <= tx_q[CMD_W-1];
                        tx_q   <= {tx_q[CMD_W-2:0], 1'b0};
                    end else begin
                        mosi_q <= 1'b0;
                        if (!rd_frame_q) begin
                            state_q <= S_GAP;
                            cnt_q   <= GAP_LD;
                            ss_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (RD_WAIT > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LD;
                        end else begin
                            state_q <= S_RECV;
                            cnt_q   <= RECV_LD;
                            rx_q    <= {rx_q[DATA_W-2:0], miso};
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_RECV;
                        cnt_q   <= RECV_LD;
                        rx_q    <= {rx_q[DATA_W-2:0], miso};
                    end
                end
                // First sample is taken on the edge entering RECV, so the exit edge does not sample.
                S_RECV: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        rx_q  <= {rx_q[DATA_W-2:0], miso};
                    end else begin
                        state_q    <= S_GAP;
                        cnt_q      <= GAP_LD;
                        ss_n_q     <= 1'b1;
                        done_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= rx_q;
                    end
                end
                S_GAP: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ss_n     = ss_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a small slave+RAM model answers frames, a scoreboard
// holds expected frame contents, and a second instance covers the RD_WAIT=0 build.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int RDW = 2;
    localparam int GP  = 1;

    typedef struct {
        logic [10:0] bits;
        int          len;
        logic        rd;
        logic [7:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] cmd_word = 10'h0;
    logic       miso = 1'b0;
    logic       busy, done, rd_valid, ss_n, mosi;
    logic [7:0] rd_data;

    logic       start_w = 1'b0;
    logic [9:0] cmd_word_w = 10'h0;
    logic       miso_w = 1'b0;
    logic       busy_w, done_w, rd_valid_w, ss_n_w, mosi_w;
    logic [7:0] rd_data_w;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int          c = 0;
    int          g = 100;
    int          cyc = 0;
    int          done_cyc = -100;
    logic [10:0] mbits = '0;
    logic [7:0]  ram [256];
    logic [7:0]  waddr = 8'h0;
    logic [7:0]  raddr = 8'h0;
    logic [7:0]  reply = 8'h0;
    logic [7:0]  last_rd = 8'h0;

    spi_master_ctrl #(.RD_WAIT(RDW), .GAP(GP)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_word(cmd_word),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    spi_master_ctrl #(.RD_WAIT(0), .GAP(3)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .start(start_w), .cmd_word(cmd_word_w),
        .busy(busy_w), .done(done_w), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
        .ss_n(ss_n_w), .mosi(mosi_w), .miso(miso_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave/RAM model plus frame monitor for the main instance.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            c = 0;
            g = 100;
            miso = 1'b0;
            last_rd = 8'h0;
        end else if (!ss_n) begin
            c++;
            check("busy_in_frame", 32'(busy), 32'd1);
            check("done_in_frame", 32'(done), 32'd0);
            if (c <= 11) mbits = {mbits[9:0], mosi};
            else check("mosi_zero_after_cmd", 32'(mosi), 32'd0);
            if (c == 11) begin
                case (mbits[9:8])
                    WR_ADDR: waddr = mbits[7:0];
                    WR_DATA: ram[waddr] = mbits[7:0];
                    RD_ADDR: raddr = mbits[7:0];
                    default: reply = ram[raddr];
                endcase
            end
            if (c >= 11 + RDW && c <= 18 + RDW) miso = reply[3'(7 - (c - 11 - RDW))];
            else miso = 1'b0;
        end else begin
            miso = 1'b0;
            if (c != 0) begin
                check("done_pulse", 32'(done), 32'd1);
                check("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("frame_bits", 32'(mbits), 32'(e.bits));
                    check("frame_len", 32'(c), 32'(e.len));
                    check("rd_valid", 32'(rd_valid), 32'(e.rd));
                    if (e.rd) last_rd = e.data;
                    check("rd_data", 32'(rd_data), 32'(last_rd));
                end
                g = 1;
                done_cyc = cyc;
            end else begin
                check("done_idle", 32'(done), 32'd0);
                check("rd_valid_idle", 32'(rd_valid), 32'd0);
                if (g < 100) g++;
            end
            check("busy_gap", 32'(busy), 32'(g <= GP));
            c = 0;
        end
    end

    task automatic send(input logic [9:0] cw, input int len, input logic [7:0] d, input bit b2b);
        exp_t e;
        bit   acc;
        logic p;
        acc = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cmd_word = cw;
        e.bits = {cw[9], cw};
        e.len  = len;
        e.rd   = (cw[9:8] == RD_DATA);
        e.data = d;
        sb.push_back(e);
        for (int i = 0; i < 200 && !acc; i++) begin
            p = ss_n;
            @(posedge clk);
            #1;
            if (p && !ss_n) acc = 1'b1;
        end
        check("accepted", 32'(acc), 32'd1);
        if (b2b) check("b2b_spacing", 32'(cyc - done_cyc), 32'(GP + 1));
        check("mosi_first", 32'(mosi), 32'(cw[9]));
        check("busy_accept", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        cmd_word = 10'h0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h20] = 8'hA5;

        #1 rst_n = 1'b0;
        #2;
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(10'h00D, 11, 8'h00, 1'b0);
        wait_idle();

        send(10'h108, 11, 8'h00, 1'b0);
        send(10'h20D, 11, 8'h00, 1'b1);
        wait_idle();

        send(10'h30D, 11 + 8 + RDW, 8'h08, 1'b0);
        wait_idle();

        send(10'h220, 11, 8'h00, 1'b0);
        send(10'h3AA, 11 + 8 + RDW, 8'hA5, 1'b0);
        wait_idle();

        // A start pulse mid-frame with a different word must leave no trace.
        send(10'h155, 11, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        cmd_word = 10'h3FF;
        @(negedge clk);
        start = 1'b0;
        cmd_word = 10'h0;
        wait_idle();

        send(10'h30D, 11 + 8 + RDW, 8'hA5, 1'b0);
        repeat (4) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ss_n", 32'(ss_n), 32'd1);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_rd_data", 32'(rd_data), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(10'h00D, 11, 8'h00, 1'b0);
        wait_idle();

        // RD_WAIT=0, GAP=3 instance driven cycle by cycle from edge T.
        @(negedge clk);
        start_w = 1'b1;
        cmd_word_w = 10'h3C3;
        @(posedge clk);
        #1;
        check("w0_accept_ss_n", 32'(ss_n_w), 32'd0);
        @(negedge clk);
        start_w = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            logic [7:0] pat;
            pat = 8'h5C;
            @(posedge clk);
            #1;
            if (j >= 10 && j <= 17) miso_w = pat[3'(17 - j)];
            else miso_w = 1'b0;
            if (j == 18) begin
                check("w0_ss_n_before_end", 32'(ss_n_w), 32'd0);
                check("w0_no_early_done", 32'(done_w), 32'd0);
            end
            if (j == 19) begin
                check("w0_done", 32'(done_w), 32'd1);
                check("w0_rd_valid", 32'(rd_valid_w), 32'd1);
                check("w0_ss_n_end", 32'(ss_n_w), 32'd1);
                check("w0_rd_data", 32'(rd_data_w), 32'(pat));
            end
            if (j == 21) check("w0_busy_in_gap", 32'(busy_w), 32'd1);
            if (j == 22) check("w0_busy_fall", 32'(busy_w), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
